// File: rtl/tern_pp_accum.sv
// -----------------------------------------------------------------------------
// tern_pp_accum
//   Accumulator stage of a digit-serial balanced-ternary multiplier. Each cycle
//   it may take one partial-product vector (a times one digit of b, b fed
//   LSB-first). It shift-adds these vectors into a 2p-digit product and
//   presents the finished product on a valid/ready output register.
//   Digit code: 2'b00=-1, 2'b01=0, 2'b10=+1, 2'b11=illegal (read as 0).
//
// Build option
//   TERN_ACC_DIGIT_CHK_EN : flag 2'b11 digits on accepted cycles in err
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   pp_valid   pp_i/pp_first/pp_last valid (no backpressure)
//   pp_first   vector for b digit 0 (starts a product)
//   pp_last    vector for b digit p-1 (ends a product)
//   pp_i       p partial-product digits, digit k at [2k+1:2k]
//   res_valid  res_o holds an unconsumed product
//   res_ready  consumer accepts res_o when res_valid && res_ready
//   res_o      2p product digits, LSB digit at [1:0]
//   busy       a product is being accumulated
//   err        sticky protocol/digit error
//   ovf        sticky: a product was committed over an unconsumed one
// -----------------------------------------------------------------------------
module tern_pp_accum #(
    parameter int p = 33
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pp_valid,
    input  logic           pp_first,
    input  logic           pp_last,
    input  logic [2*p-1:0] pp_i,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [4*p-1:0] res_o,
    output logic           busy,
    output logic           err,
    output logic           ovf
);

    typedef enum logic {IDLE, ACC} state_e;

    localparam int            CW       = (p > 1) ? $clog2(p) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(p - 1);
    localparam logic [2*p-1:0] ZERO_P  = {p{2'b01}};

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [p-1:0][1:0]      acc_hi_q, acc_hi_d;
    logic [p-1:0][1:0]      acc_lo_q, acc_lo_d;
    logic [2*p-1:0][1:0]    res_q, res_d;
    logic                   res_valid_q, res_valid_d;
    logic                   err_q, err_d;
    logic                   ovf_q, ovf_d;

    logic [p-1:0][1:0]      pp_v;
    logic [p:0][1:0]        s;
    logic [p-1:0][1:0]      lo_base;
    logic [p-1:0][1:0]      lo_new;
    logic                   accept;
    logic                   commit;
    logic                   proto_err;
    logic                   digit_err;
    logic [CW-1:0]          idx;

    assign pp_v = pp_i;

    // Digit code to signed value; the illegal code reads as zero.
    function automatic logic signed [2:0] dec(input logic [1:0] c);
        case (c)
            2'b00:   dec = 3'b111;
            2'b10:   dec = 3'b001;
            default: dec = 3'b000;
        endcase
    endfunction

    // s = acc_hi + pp_i, balanced-ternary ripple add producing p+1 digits.
    // A new product starts from an all-zero high half.
    always_comb begin
        logic signed [2:0] carry;
        logic signed [2:0] sum;
        carry = 3'b000;
        sum   = 3'b000;
        s     = '0;
        for (int k = 0; k < p; k++) begin
            sum = (pp_first ? 3'sd0 : dec(acc_hi_q[k])) + dec(pp_v[k]) + carry;
            case (sum)
                3'b011:  begin s[k] = 2'b01; carry = 3'b001; end // +3
                3'b010:  begin s[k] = 2'b00; carry = 3'b001; end // +2
                3'b001:  begin s[k] = 2'b10; carry = 3'b000; end // +1
                3'b111:  begin s[k] = 2'b00; carry = 3'b000; end // -1
                3'b110:  begin s[k] = 2'b10; carry = 3'b111; end // -2
                3'b101:  begin s[k] = 2'b01; carry = 3'b111; end // -3
                default: begin s[k] = 2'b01; carry = 3'b000; end //  0
            endcase
        end
        case (carry)
            3'b001:  s[p] = 2'b10;
            3'b111:  s[p] = 2'b00;
            default: s[p] = 2'b01;
        endcase
    end

    // Digit 0 of the step sum enters the low half from the top, so after p
    // steps the first sum digit has walked down to product digit 0.
    assign lo_base = pp_first ? ZERO_P : acc_lo_q;
    generate
        if (p > 1) begin : g_lo_shift
            assign lo_new = {s[0], lo_base[p-1:1]};
        end else begin : g_lo_single
            assign lo_new = s[0];
        end
    endgenerate

`ifdef TERN_ACC_DIGIT_CHK_EN
    always_comb begin
        digit_err = 1'b0;
        for (int k = 0; k < p; k++) begin
            if (pp_v[k] == 2'b11) digit_err = 1'b1;
        end
    end
`else
    assign digit_err = 1'b0;
`endif

    // Sequencing: idx is the b digit position of the incoming vector.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        commit    = 1'b0;
        proto_err = 1'b0;
        accept    = pp_valid && (pp_first || state_q == ACC);
        idx       = pp_first ? '0 : cnt_q;
        if (pp_valid && !accept) proto_err = 1'b1;
        if (accept) begin
            if (state_q == ACC && pp_first) proto_err = 1'b1;
            if (pp_last && idx == LAST_IDX) begin
                commit  = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end else if (pp_last || idx == LAST_IDX) begin
                proto_err = 1'b1;
                state_d   = IDLE;
                cnt_d     = '0;
            end else begin
                state_d = ACC;
                cnt_d   = idx + CW'(1);
            end
        end
    end

    always_comb begin
        acc_hi_d    = accept ? s[p:1] : acc_hi_q;
        acc_lo_d    = accept ? lo_new : acc_lo_q;
        res_d       = commit ? {s[p:1], lo_new} : res_q;
        // A commit in the same cycle as a handshake keeps res_valid high.
        res_valid_d = commit ? 1'b1 : (res_valid_q && res_ready) ? 1'b0 : res_valid_q;
        ovf_d       = ovf_q | (commit & res_valid_q & ~res_ready);
        err_d       = err_q | proto_err | (accept & digit_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_hi_q    <= ZERO_P;
            acc_lo_q    <= ZERO_P;
            res_q       <= {2{ZERO_P}};
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
        end
    end

    assign res_o     = res_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q == ACC);
    assign err       = err_q;
    assign ovf       = ovf_q;

endmodule
